// File: rtl/feedback_seq_gen.sv
// Feedback shift-register sequence generator with runtime Fibonacci/Galois structure,
// programmable taps, seed load, all-zero lock-up recovery and sequence-period measurement.
module feedback_seq_gen #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
  parameter logic [WIDTH-1:0] SEED  = 8'h01,
  parameter bit               MODE  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] tap_in,
  input  logic             mode_in,
  output logic [WIDTH-1:0] state,
  output logic             bit_out,
  output logic             lockup,
  output logic [WIDTH-1:0] period,
  output logic             period_valid
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] taps_r;
  logic             mode_r;
  logic [WIDTH-1:0] ref_r;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] period_r;
  logic             period_valid_r;
  logic             lockup_r;

  logic             fib_fb;
  logic [WIDTH-1:0] fib_next;
  logic [WIDTH-1:0] gal_next;
  logic [WIDTH-1:0] next_state;

  // Both structures are computed every cycle; mode_r only picks which one is taken.
  always_comb begin
    fib_fb     = ^(state_r & taps_r);
    fib_next   = {state_r[WIDTH-2:0], fib_fb};
    gal_next   = {state_r[WIDTH-2:0], 1'b0} ^ ({WIDTH{state_r[WIDTH-1]}} & taps_r);
    next_state = mode_r ? gal_next : fib_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r        <= SEED;
      taps_r         <= TAPS;
      mode_r         <= MODE;
      ref_r          <= SEED;
      cnt            <= '0;
      period_r       <= '0;
      period_valid_r <= 1'b0;
      lockup_r       <= 1'b0;
    end else begin
      lockup_r <= 1'b0;
      if (load) begin
        state_r        <= load_val;
        ref_r          <= load_val;
        taps_r         <= tap_in;
        mode_r         <= mode_in;
        cnt            <= '0;
        period_valid_r <= 1'b0;
      end else if (en) begin
        if (state_r == '0) begin
          // All-zero is a fixed point of both structures, so restart from SEED instead of stepping.
          state_r        <= SEED;
          ref_r          <= SEED;
          cnt            <= '0;
          period_valid_r <= 1'b0;
          lockup_r       <= 1'b1;
        end else begin
          state_r <= next_state;
          if (next_state == ref_r) begin
            cnt <= '0;
            // A saturated count means the true period is unknown, so it is never reported.
            if (cnt != CNT_MAX) begin
              period_r       <= cnt + ONE;
              period_valid_r <= 1'b1;
            end
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + ONE;
          end
        end
      end
    end
  end

  assign state        = state_r;
  assign bit_out      = state_r[WIDTH-1];
  assign lockup       = lockup_r;
  assign period       = period_r;
  assign period_valid = period_valid_r;

endmodule

// File: tb/tb_feedback_seq_gen.sv
// Directed bench for feedback_seq_gen: a 3-bit instance for sequence/flag checks
// and a default 8-bit instance for the full-length period measurement.
module tb_feedback_seq_gen;

  logic       clk;
  logic       rst_n;

  logic       en3, load3, mode3;
  logic [2:0] loadVal3, tapIn3;
  logic [2:0] state3, period3;
  logic       bitOut3, lockup3, periodValid3;

  logic       en8, load8, mode8;
  logic [7:0] loadVal8, tapIn8;
  logic [7:0] state8, period8;
  logic       bitOut8, lockup8, periodValid8;

  int checks;
  int errors;

  feedback_seq_gen #(
    .WIDTH(3), .TAPS(3'b110), .SEED(3'b001), .MODE(1'b0)
  ) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en3), .load(load3),
    .load_val(loadVal3), .tap_in(tapIn3), .mode_in(mode3),
    .state(state3), .bit_out(bitOut3), .lockup(lockup3),
    .period(period3), .period_valid(periodValid3)
  );

  feedback_seq_gen dut8 (
    .clk(clk), .rst_n(rst_n), .en(en8), .load(load8),
    .load_val(loadVal8), .tap_in(tapIn8), .mode_in(mode8),
    .state(state8), .bit_out(bitOut8), .lockup(lockup8),
    .period(period8), .period_valid(periodValid8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the 3-bit instance for one edge, then settle just after it.
  task automatic applyStimulus(input logic ld, input logic e, input logic [2:0] val,
                               input logic [2:0] taps, input logic md);
    load3    = ld;
    en3      = e;
    loadVal3 = val;
    tapIn3   = taps;
    mode3    = md;
    @(posedge clk);
    #1;
  endtask

  logic [2:0] fibExp [7];
  logic [2:0] galExp [7];
  logic [2:0] reloadExp [7];
  logic [2:0] expVal;
  logic       lockupSeen;
  int         firstValid;

  initial begin
    checks = 0;
    errors = 0;
    fibExp    = '{3'b010, 3'b101, 3'b011, 3'b111, 3'b110, 3'b100, 3'b001};
    galExp    = '{3'b010, 3'b100, 3'b011, 3'b110, 3'b111, 3'b101, 3'b001};
    reloadExp = '{3'b011, 3'b111, 3'b110, 3'b100, 3'b001, 3'b010, 3'b101};

    rst_n = 1'b0;
    en3 = 1'b0; load3 = 1'b0; mode3 = 1'b0; loadVal3 = '0; tapIn3 = '0;
    en8 = 1'b0; load8 = 1'b0; mode8 = 1'b0; loadVal8 = '0; tapIn8 = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_state3", 32'(state3), 32'h1);
    checkOutput("rst_bitout3", 32'(bitOut3), 32'h0);
    checkOutput("rst_lockup3", 32'(lockup3), 32'h0);
    checkOutput("rst_period3", 32'(period3), 32'h0);
    checkOutput("rst_valid3", 32'(periodValid3), 32'h0);
    checkOutput("rst_state8", 32'(state8), 32'h01);
    rst_n = 1'b1;

    // Fibonacci, taps 110
    applyStimulus(1'b1, 1'b0, 3'b001, 3'b110, 1'b0);
    checkOutput("fib_load", 32'(state3), 32'h1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
      expVal = fibExp[i];
      checkOutput($sformatf("fib_state%0d", i), 32'(state3), 32'(expVal));
      checkOutput($sformatf("fib_bit%0d", i), 32'(bitOut3), 32'(expVal[2]));
      if (i < 6) checkOutput($sformatf("fib_valid%0d", i), 32'(periodValid3), 32'h0);
    end
    checkOutput("fib_period", 32'(period3), 32'h7);
    checkOutput("fib_valid", 32'(periodValid3), 32'h1);

    // Galois, taps 011; load clears valid but holds the old period
    applyStimulus(1'b1, 1'b0, 3'b001, 3'b011, 1'b1);
    checkOutput("gal_load", 32'(state3), 32'h1);
    checkOutput("gal_load_valid", 32'(periodValid3), 32'h0);
    checkOutput("gal_load_period", 32'(period3), 32'h7);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
      expVal = galExp[i];
      checkOutput($sformatf("gal_state%0d", i), 32'(state3), 32'(expVal));
    end
    checkOutput("gal_period", 32'(period3), 32'h7);
    checkOutput("gal_valid", 32'(periodValid3), 32'h1);

    // Asynchronous reset between edges
    applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_state3", 32'(state3), 32'h1);
    checkOutput("async_period3", 32'(period3), 32'h0);
    checkOutput("async_valid3", 32'(periodValid3), 32'h0);
    #2;
    rst_n = 1'b1;

    // Lock-up recovery from an all-zero load
    applyStimulus(1'b1, 1'b0, 3'b000, 3'b110, 1'b0);
    checkOutput("zero_load", 32'(state3), 32'h0);
    checkOutput("zero_load_lockup", 32'(lockup3), 32'h0);
    applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
    checkOutput("lock_pulse", 32'(lockup3), 32'h1);
    checkOutput("lock_state", 32'(state3), 32'h1);
    checkOutput("lock_valid", 32'(periodValid3), 32'h0);
    applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
    checkOutput("lock_drop", 32'(lockup3), 32'h0);
    checkOutput("lock_next", 32'(state3), 32'h2);
    repeat (6) applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
    checkOutput("lock_return", 32'(state3), 32'h1);
    checkOutput("lock_period", 32'(period3), 32'h7);
    checkOutput("lock_period_valid", 32'(periodValid3), 32'h1);

    // load and en together: load wins, measurement restarts from the new value
    applyStimulus(1'b1, 1'b1, 3'b101, 3'b110, 1'b0);
    checkOutput("ldEn_state", 32'(state3), 32'h5);
    checkOutput("ldEn_valid", 32'(periodValid3), 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 3'b000, 3'b000, 1'b0);
      checkOutput($sformatf("hold%0d", i), 32'(state3), 32'h5);
    end
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 3'b000, 3'b000, 1'b0);
      expVal = reloadExp[i];
      checkOutput($sformatf("reload_state%0d", i), 32'(state3), 32'(expVal));
      if (i < 6) checkOutput($sformatf("reload_valid%0d", i), 32'(periodValid3), 32'h0);
    end
    checkOutput("reload_period", 32'(period3), 32'h7);
    checkOutput("reload_valid", 32'(periodValid3), 32'h1);

    // Default 8-bit instance, free-running
    en3 = 1'b0;
    en8 = 1'b1;
    lockupSeen = 1'b0;
    firstValid = 0;
    for (int i = 1; i <= 300; i++) begin
      @(posedge clk);
      #1;
      lockupSeen = lockupSeen | lockup8;
      if (periodValid8 && firstValid == 0) firstValid = i;
    end
    checkOutput("w8_first_valid", 32'(firstValid), 32'd255);
    checkOutput("w8_period", 32'(period8), 32'd255);
    checkOutput("w8_valid", 32'(periodValid8), 32'h1);
    checkOutput("w8_lockup", 32'(lockupSeen), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
